// File: rtl/snake_body_engine.sv
// -----------------------------------------------------------------------------
// snake_body_engine
//
// Parametrised snake body datapath. Keeps MAX_LENGTH segments in cell
// coordinates, advances the whole body one cell every TICK_DIV cycles while
// enabled, wraps at the screen edges, grows on request, flags self-collision
// and answers per-pixel head/body hit queries for the colour path.
//
// Ports:
//   CLK           system clock
//   RESET         synchronous, active-high reset (overrides everything)
//   ENABLE        high while the game is in play; gates the move tick
//   DIRECTION     requested heading: 0 up, 1 right, 2 down, 3 left
//   GROW          one-cycle pulse, request one extra segment
//   QUERY_X/Y     cell under the current pixel
//   HIT_HEAD      registered: query cell equals segment 0
//   HIT_BODY      registered: query cell equals an active segment 1..LENGTH-1
//   HEAD_X/Y      segment 0 coordinates
//   LENGTH        active segment count
//   STEP          one-cycle pulse after each move
//   SELF_COLLIDE  sticky self-collision flag; freezes movement until reset
// -----------------------------------------------------------------------------
module snake_body_engine #(
  parameter int MAX_LENGTH  = 32,
  parameter int INIT_LENGTH = 4,
  parameter int MAX_X       = 159,
  parameter int MAX_Y       = 119,
  parameter int X_WIDTH     = 8,
  parameter int Y_WIDTH     = 7,
  parameter int LEN_WIDTH   = 6,
  parameter int TICK_DIV    = 10000000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 ENABLE,
  input  logic [1:0]           DIRECTION,
  input  logic                 GROW,
  input  logic [X_WIDTH-1:0]   QUERY_X,
  input  logic [Y_WIDTH-1:0]   QUERY_Y,
  output logic                 HIT_HEAD,
  output logic                 HIT_BODY,
  output logic [X_WIDTH-1:0]   HEAD_X,
  output logic [Y_WIDTH-1:0]   HEAD_Y,
  output logic [LEN_WIDTH-1:0] LENGTH,
  output logic                 STEP,
  output logic                 SELF_COLLIDE
);

  localparam int TICK_W = $clog2(TICK_DIV);

  localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0]    TICK_ONE  = TICK_W'(1);
  localparam logic [X_WIDTH-1:0]   X_LAST    = X_WIDTH'(MAX_X);
  localparam logic [X_WIDTH-1:0]   X_ONE     = X_WIDTH'(1);
  localparam logic [Y_WIDTH-1:0]   Y_LAST    = Y_WIDTH'(MAX_Y);
  localparam logic [Y_WIDTH-1:0]   Y_ONE     = Y_WIDTH'(1);
  localparam logic [Y_WIDTH-1:0]   Y_MID     = Y_WIDTH'(MAX_Y / 2);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX   = LEN_WIDTH'(MAX_LENGTH);
  localparam logic [LEN_WIDTH-1:0] LEN_INIT  = LEN_WIDTH'(INIT_LENGTH);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);

  // Segment store: index 0 is the head. Kept in flops because every entry is
  // compared in parallel each cycle.
  logic [X_WIDTH-1:0]   seg_x_reg [MAX_LENGTH];
  logic [Y_WIDTH-1:0]   seg_y_reg [MAX_LENGTH];

  logic [1:0]           heading_reg, heading_next;
  logic [LEN_WIDTH-1:0] length_reg, length_next;
  logic [1:0]           pending_reg, pending_next;
  logic [TICK_W-1:0]    tick_reg, tick_next;
  logic                 step_reg;
  logic                 collide_reg;
  logic                 hit_head_reg;
  logic                 hit_body_reg;

  logic                 run;
  logic                 step_now;
  logic [X_WIDTH-1:0]   head_x_next;
  logic [Y_WIDTH-1:0]   head_y_next;
  logic [MAX_LENGTH-1:0] body_hit_vec;
  logic [MAX_LENGTH-1:0] self_hit_vec;

  // Move tick: frozen (not cleared) when disabled or after a collision.
  always_comb begin
    run       = ENABLE && !collide_reg;
    step_now  = run && (tick_reg == TICK_LAST);
    tick_next = tick_reg;
    if (step_now) begin
      tick_next = '0;
    end else if (run) begin
      tick_next = tick_reg + TICK_ONE;
    end
  end

  // A reversal request is ignored; XOR with 2 gives the opposite heading.
  always_comb begin
    heading_next = heading_reg;
    if (step_now && (DIRECTION != (heading_reg ^ 2'b10))) begin
      heading_next = DIRECTION;
    end
  end

  // New head position along the updated heading, with edge wrap.
  always_comb begin
    head_x_next = seg_x_reg[0];
    head_y_next = seg_y_reg[0];
    case (heading_next)
      2'd0:    head_y_next = (seg_y_reg[0] == '0)     ? Y_LAST : seg_y_reg[0] - Y_ONE;
      2'd1:    head_x_next = (seg_x_reg[0] == X_LAST) ? '0     : seg_x_reg[0] + X_ONE;
      2'd2:    head_y_next = (seg_y_reg[0] == Y_LAST) ? '0     : seg_y_reg[0] + Y_ONE;
      default: head_x_next = (seg_x_reg[0] == '0)     ? X_LAST : seg_x_reg[0] - X_ONE;
    endcase
  end

  // Growth consumes the pending count as it stood before this edge; a GROW
  // arriving on the same edge is added afterwards so it lands on the next step.
  always_comb begin
    length_next  = length_reg;
    pending_next = pending_reg;
    if (step_now && (pending_reg != 2'd0)) begin
      if (length_reg < LEN_MAX) begin
        length_next  = length_reg + LEN_ONE;
        pending_next = pending_reg - 2'd1;
      end else begin
        pending_next = 2'd0;
      end
    end
    if (GROW && (pending_next != 2'd3)) begin
      pending_next = pending_next + 2'd1;
    end
  end

  // Per-segment comparators. Segment 0 never counts as body.
  generate
    for (genvar gi = 0; gi < MAX_LENGTH; gi++) begin : gen_cmp
      if (gi == 0) begin : gen_head
        assign body_hit_vec[gi] = 1'b0;
        assign self_hit_vec[gi] = 1'b0;
      end else begin : gen_body
        assign body_hit_vec[gi] = (LEN_WIDTH'(gi) < length_reg) &&
                                  (seg_x_reg[gi] == QUERY_X) &&
                                  (seg_y_reg[gi] == QUERY_Y);
        assign self_hit_vec[gi] = (LEN_WIDTH'(gi) < length_reg) &&
                                  (seg_x_reg[gi] == seg_x_reg[0]) &&
                                  (seg_y_reg[gi] == seg_y_reg[0]);
      end
    end
  endgenerate

  // Body shift register; the whole depth shifts so a later grow exposes the
  // position that was the previous tail.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < MAX_LENGTH; i++) begin
        seg_x_reg[i] <= X_WIDTH'(MAX_X / 2 - i);
        seg_y_reg[i] <= Y_MID;
      end
    end else if (step_now) begin
      seg_x_reg[0] <= head_x_next;
      seg_y_reg[0] <= head_y_next;
      for (int i = 1; i < MAX_LENGTH; i++) begin
        seg_x_reg[i] <= seg_x_reg[i-1];
        seg_y_reg[i] <= seg_y_reg[i-1];
      end
    end
  end

  // Control state. Collision is judged in the cycle after a step, against the
  // already-shifted body and updated length.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      heading_reg  <= 2'd1;
      length_reg   <= LEN_INIT;
      pending_reg  <= 2'd0;
      tick_reg     <= '0;
      step_reg     <= 1'b0;
      collide_reg  <= 1'b0;
      hit_head_reg <= 1'b0;
      hit_body_reg <= 1'b0;
    end else begin
      heading_reg  <= heading_next;
      length_reg   <= length_next;
      pending_reg  <= pending_next;
      tick_reg     <= tick_next;
      step_reg     <= step_now;
      collide_reg  <= collide_reg | (step_reg & (|self_hit_vec));
      hit_head_reg <= (seg_x_reg[0] == QUERY_X) && (seg_y_reg[0] == QUERY_Y);
      hit_body_reg <= |body_hit_vec;
    end
  end

  assign HIT_HEAD     = hit_head_reg;
  assign HIT_BODY     = hit_body_reg;
  assign HEAD_X       = seg_x_reg[0];
  assign HEAD_Y       = seg_y_reg[0];
  assign LENGTH       = length_reg;
  assign STEP         = step_reg;
  assign SELF_COLLIDE = collide_reg;

endmodule

// File: tb/tb_snake_body_engine.sv
// -----------------------------------------------------------------------------
// tb_snake_body_engine
//
// Two engines (INIT_LENGTH 4 and 5, MAX_LENGTH 6, TICK_DIV 4) share one set of
// inputs. A list-of-cells reference model tracks each one; every cycle all
// outputs are compared, with directed scenarios followed by a random phase.
// -----------------------------------------------------------------------------
module tb_snake_body_engine;

  localparam int TD = 4;
  localparam int ML = 6;
  localparam int MX = 159;
  localparam int MY = 119;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] dir;
  logic       grow;
  logic [7:0] qx;
  logic [6:0] qy;

  logic       a_hit_head, a_hit_body, a_step, a_coll;
  logic [7:0] a_head_x;
  logic [6:0] a_head_y;
  logic [5:0] a_len;
  logic       b_hit_head, b_hit_body, b_step, b_coll;
  logic [7:0] b_head_x;
  logic [6:0] b_head_y;
  logic [5:0] b_len;

  int checks = 0;
  int errors = 0;

  // Reference model state, [0] = engine a, [1] = engine b.
  int m_x [2][ML];
  int m_y [2][ML];
  int m_len [2];
  int m_pend [2];
  int m_tick [2];
  int m_head [2];
  int m_step [2];
  int m_coll [2];
  int m_hh [2];
  int m_hb [2];

  snake_body_engine #(
    .MAX_LENGTH(ML), .INIT_LENGTH(4), .MAX_X(MX), .MAX_Y(MY),
    .X_WIDTH(8), .Y_WIDTH(7), .LEN_WIDTH(6), .TICK_DIV(TD)
  ) dut_a (
    .CLK(clk), .RESET(rst), .ENABLE(en), .DIRECTION(dir), .GROW(grow),
    .QUERY_X(qx), .QUERY_Y(qy),
    .HIT_HEAD(a_hit_head), .HIT_BODY(a_hit_body),
    .HEAD_X(a_head_x), .HEAD_Y(a_head_y), .LENGTH(a_len),
    .STEP(a_step), .SELF_COLLIDE(a_coll)
  );

  snake_body_engine #(
    .MAX_LENGTH(ML), .INIT_LENGTH(5), .MAX_X(MX), .MAX_Y(MY),
    .X_WIDTH(8), .Y_WIDTH(7), .LEN_WIDTH(6), .TICK_DIV(TD)
  ) dut_b (
    .CLK(clk), .RESET(rst), .ENABLE(en), .DIRECTION(dir), .GROW(grow),
    .QUERY_X(qx), .QUERY_Y(qy),
    .HIT_HEAD(b_hit_head), .HIT_BODY(b_hit_body),
    .HEAD_X(b_head_x), .HEAD_Y(b_head_y), .LENGTH(b_len),
    .STEP(b_step), .SELF_COLLIDE(b_coll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int  nx, ny, hh, hb;
    bit  self_hit, adv, do_step;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        for (int i = 0; i < ML; i++) begin
          m_x[m][i] = MX / 2 - i;
          m_y[m][i] = MY / 2;
        end
        m_len[m] = 4 + m; m_pend[m] = 0; m_tick[m] = 0; m_head[m] = 1;
        m_step[m] = 0; m_coll[m] = 0; m_hh[m] = 0; m_hb[m] = 0;
      end else begin
        hh = (int'(qx) == m_x[m][0] && int'(qy) == m_y[m][0]) ? 1 : 0;
        hb = 0;
        self_hit = 1'b0;
        for (int j = 1; j < m_len[m]; j++) begin
          if (int'(qx) == m_x[m][j] && int'(qy) == m_y[m][j]) hb = 1;
          if (m_x[m][0] == m_x[m][j] && m_y[m][0] == m_y[m][j]) self_hit = 1'b1;
        end
        adv     = en && (m_coll[m] == 0);
        do_step = adv && (m_tick[m] == TD - 1);
        if (m_step[m] == 1 && self_hit) m_coll[m] = 1;
        if (adv) m_tick[m] = (m_tick[m] + 1) % TD;
        if (do_step) begin
          if (int'(dir) != (m_head[m] + 2) % 4) m_head[m] = int'(dir);
          nx = m_x[m][0];
          ny = m_y[m][0];
          case (m_head[m])
            0:       ny = (ny == 0)  ? MY : ny - 1;
            1:       nx = (nx == MX) ? 0  : nx + 1;
            2:       ny = (ny == MY) ? 0  : ny + 1;
            default: nx = (nx == 0)  ? MX : nx - 1;
          endcase
          for (int i = ML - 1; i > 0; i--) begin
            m_x[m][i] = m_x[m][i-1];
            m_y[m][i] = m_y[m][i-1];
          end
          m_x[m][0] = nx;
          m_y[m][0] = ny;
          if (m_pend[m] > 0) begin
            if (m_len[m] < ML) begin
              m_len[m]++;
              m_pend[m]--;
            end else begin
              m_pend[m] = 0;
            end
          end
        end
        if (grow && m_pend[m] < 3) m_pend[m]++;
        m_step[m] = do_step ? 1 : 0;
        m_hh[m]   = hh;
        m_hb[m]   = hb;
      end
    end
  endtask

  task automatic compare_all();
    check_value("a_head_x",   a_head_x,   m_x[0][0]);
    check_value("a_head_y",   a_head_y,   m_y[0][0]);
    check_value("a_length",   a_len,      m_len[0]);
    check_value("a_step",     a_step,     m_step[0]);
    check_value("a_collide",  a_coll,     m_coll[0]);
    check_value("a_hit_head", a_hit_head, m_hh[0]);
    check_value("a_hit_body", a_hit_body, m_hb[0]);
    check_value("b_head_x",   b_head_x,   m_x[1][0]);
    check_value("b_head_y",   b_head_y,   m_y[1][0]);
    check_value("b_length",   b_len,      m_len[1]);
    check_value("b_step",     b_step,     m_step[1]);
    check_value("b_collide",  b_coll,     m_coll[1]);
    check_value("b_hit_head", b_hit_head, m_hh[1]);
    check_value("b_hit_body", b_hit_body, m_hb[1]);
  endtask

  // One clock: predict, clock, compare. RESET and GROW act as one-cycle pulses.
  task automatic one_cycle();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
    rst  = 1'b0;
    grow = 1'b0;
  endtask

  // Clock until engine a has just stepped (STEP high now); returns cycles used.
  task automatic run_until_step(output int n);
    n = 0;
    do begin
      one_cycle();
      n++;
    end while (m_step[0] == 0 && n < 4 * TD);
    if (m_step[0] == 0) check_value("step_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    one_cycle();
  endtask

  int n;
  int idx;

  initial begin
    rst = 1'b0; en = 1'b0; dir = 2'd1; grow = 1'b0; qx = 8'd79; qy = 7'd59;
    do_reset();
    check_value("rst_head_x", a_head_x, 79);
    check_value("rst_head_y", a_head_y, 59);
    check_value("rst_length", a_len, 4);
    check_value("rst_step", a_step, 0);
    check_value("rst_collide", a_coll, 0);

    // Queries with the game idle.
    qx = 8'd79; qy = 7'd59; one_cycle();
    check_value("query_head", a_hit_head, 1);
    qx = 8'd76; one_cycle();
    check_value("query_body_tail", a_hit_body, 1);
    qx = 8'd75; one_cycle();
    check_value("query_inactive", a_hit_body, 0);
    check_value("query_len5_tail", b_hit_body, 1);

    // Plain movement to the right.
    en = 1'b1; dir = 2'd1;
    run_until_step(n);
    check_value("move1_x", a_head_x, 80);
    check_value("move1_y", a_head_y, 59);
    run_until_step(n);
    check_value("move2_x", a_head_x, 81);
    check_value("step_period", n, TD);

    // Reversal request is ignored.
    dir = 2'd3;
    run_until_step(n);
    check_value("reverse_ignored_x", a_head_x, 82);
    dir = 2'd1;

    // Right-edge wrap.
    for (int k = 0; k < 200 && m_x[0][0] != MX; k++) run_until_step(n);
    check_value("at_right_edge", a_head_x, MX);
    run_until_step(n);
    check_value("wrap_x", a_head_x, 0);

    // Top-edge wrap.
    dir = 2'd0;
    for (int k = 0; k < 200 && m_y[0][0] != 0; k++) run_until_step(n);
    check_value("at_top_edge", a_head_y, 0);
    run_until_step(n);
    check_value("wrap_y", a_head_y, MY);

    // Growth to the MAX_LENGTH cap with pulses between steps.
    do_reset();
    en = 1'b1; dir = 2'd1;
    grow = 1'b1; one_cycle();
    run_until_step(n);
    check_value("grow_len5", a_len, 5);
    grow = 1'b1; one_cycle();
    run_until_step(n);
    check_value("grow_len6", a_len, 6);
    grow = 1'b1; one_cycle();
    run_until_step(n);
    check_value("grow_capped", a_len, 6);
    grow = 1'b1; one_cycle();
    run_until_step(n);
    check_value("grow_capped2", a_len, 6);
    check_value("grow_b_capped", b_len, 6);

    // GROW on the step edge takes effect one step later.
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 2 * TD && m_tick[0] != TD - 1; k++) one_cycle();
    grow = 1'b1; one_cycle();
    check_value("grow_same_edge_step", a_step, 1);
    check_value("grow_same_edge_len", a_len, 4);
    run_until_step(n);
    check_value("grow_next_step_len", a_len, 5);

    // Down, left, up: collides at length 5, not at length 4.
    do_reset();
    en = 1'b1;
    dir = 2'd2; run_until_step(n);
    dir = 2'd3; run_until_step(n);
    dir = 2'd0; run_until_step(n);
    check_value("collide_not_yet", b_coll, 0);
    one_cycle();
    check_value("collide_b", b_coll, 1);
    check_value("collide_a", a_coll, 0);
    check_value("collide_head_x", b_head_x, 78);
    check_value("collide_head_y", b_head_y, 59);
    for (int k = 0; k < 3 * TD; k++) begin
      one_cycle();
      check_value("collide_no_step", b_step, 0);
    end

    // Random phase.
    do_reset();
    for (int k = 0; k < 2500; k++) begin
      rst  = ($urandom_range(0, 149) == 0);
      en   = ($urandom_range(0, 7) != 0);
      dir  = 2'($urandom_range(0, 3));
      grow = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 0) begin
        idx = int'($urandom_range(0, ML - 1));
        qx  = 8'(m_x[$urandom_range(0, 1)][idx]);
        qy  = 7'(m_y[0][idx]);
        if ($urandom_range(0, 1) == 0) qy = 7'(m_y[1][idx]);
      end else begin
        qx = 8'($urandom_range(0, MX));
        qy = 7'($urandom_range(0, MY));
      end
      one_cycle();
    end

    // Reset in the middle of play.
    do_reset();
    en = 1'b1; dir = 2'd2;
    run_until_step(n);
    run_until_step(n);
    one_cycle();
    rst = 1'b1;
    one_cycle();
    check_value("midreset_x", a_head_x, 79);
    check_value("midreset_y", a_head_y, 59);
    check_value("midreset_len", a_len, 4);
    check_value("midreset_step", a_step, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
